tile_flusher: RTL and testbench
===============================

TILE_FLUSHER -- requirements
Module: tile_flusher

Interface
REQ-001 Parameter TILE_W, default 20, tile width in pixels.
REQ-002 Parameter TILE_H, default 45, tile height in pixels.
REQ-003 Parameter SCREEN_W, default 320, framebuffer row pitch in pixels.
REQ-004 Parameter FIFO_DEPTH, default 4, output buffer entries (power of two, >=4).
REQ-005 clk  input  1  sole clock; all logic on posedge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request to flush one tile; sampled only in IDLE.
REQ-008 x_offset  input  9  screen x of tile top-left pixel; captured on accepted start.
REQ-009 y_offset  input  8  screen y of tile top-left pixel; captured on accepted start.
REQ-010 tile_bram_read_addr  output  10  tile BRAM address = row*TILE_W + col.
REQ-011 tile_bram_read_data  input  32  tile pixel word, valid exactly 2 cycles after address; bits [15:0] = colour.
REQ-012 fb_write_addr  output  17  framebuffer address.
REQ-013 fb_write_data  output  16  pixel colour.
REQ-014 fb_write_valid  output  1  write request.
REQ-015 fb_write_ready  input  1  framebuffer accepts; transfer when valid & ready.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse after last pixel transferred.

Function
REQ-018 States: IDLE, ISSUE, DRAIN; IDLE->ISSUE on start; ISSUE->DRAIN after last read issued; DRAIN->IDLE when FIFO empty and no reads in flight.
REQ-019 Reads raster-ordered: col 0..TILE_W-1 inner, row 0..TILE_H-1 outer; 900 reads per tile at defaults.
REQ-020 One read issued per cycle in ISSUE only when (in_flight + fifo_count) < FIFO_DEPTH; otherwise address held, no issue.
REQ-021 A 2-stage valid/coordinate pipeline tracks issued reads; on arrival {addr, data[15:0]} pushed into FIFO; overflow impossible by REQ-020.
REQ-022 fb_write_addr = (y_offset+row)*SCREEN_W + (x_offset+col), computed at 17 bits, no truncation.
REQ-023 fb_write_valid = FIFO non-empty; fb_write_addr/data = FIFO head; must hold stable while valid & !ready.
REQ-024 FIFO pop only on valid & ready; push and pop same cycle keep count unchanged.
REQ-025 Throughput: with fb_write_ready held high, one transfer per cycle; first fb_write_valid 3 cycles after start accepted; done pulse 1 cycle after final transfer.
REQ-026 start while busy ignored; start coincident with done pulse not accepted (IDLE entered next cycle).
REQ-027 Pixels emitted in read order, none dropped or duplicated, under any ready pattern.
REQ-028 tile_bram_read_addr holds last value when not issuing; outputs of BRAM read when not tracked are discarded.

Reset
REQ-029 On rst: state IDLE, FIFO emptied, in-flight pipeline cleared, row/col 0, fb_write_valid 0, busy 0, done 0, tile_bram_read_addr 0.
REQ-030 rst mid-flush abandons tile immediately; next cycle behaves as post-reset IDLE; no stale write emitted.
REQ-031 rst takes priority over start in same cycle.

Verification
REQ-032 start, x=0,y=0, ready=1, BRAM word i=0x0000_0000+i -> 900 writes addr row*320+col, data=i[15:0], contiguous cycles, one done pulse.
REQ-033 start x=300,y=135 (bottom-right tile) -> first addr 43500, last addr 57599, no overflow.
REQ-034 ready random 30% high -> same 900 (addr,data) sequence as REQ-032, addr/data stable while stalled, FIFO count never >4.
REQ-035 ready=0 for 50 cycles after start -> exactly 4 reads issued then stall; on ready=1 flush completes correctly.
REQ-036 rst asserted at pixel 400 -> valid drops next cycle, busy=0, no done; new start then yields full correct 900-pixel flush.
REQ-037 start pulsed repeatedly during flush -> ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/tile_flusher.sv
// Streams one tile from tile BRAM into the framebuffer through a small FIFO.
// Reads are throttled so every read in flight already has a FIFO slot waiting for it.
module tile_flusher #(
   parameter int unsigned TILE_W     = 20,
   parameter int unsigned TILE_H     = 45,
   parameter int unsigned SCREEN_W   = 320,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [8:0]  x_offset,
   input  logic [7:0]  y_offset,
   output logic [9:0]  tile_bram_read_addr,
   input  logic [31:0] tile_bram_read_data,
   output logic [16:0] fb_write_addr,
   output logic [15:0] fb_write_data,
   output logic        fb_write_valid,
   input  logic        fb_write_ready,
   output logic        busy,
   output logic        done
);

   localparam int unsigned ColW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
   localparam int unsigned RowW = (TILE_H > 1) ? $clog2(TILE_H) : 1;
   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

   state_e            state_q, state_d;
   logic [ColW-1:0]   col_q;
   logic [RowW-1:0]   row_q;
   logic [9:0]        addr_q;
   logic [8:0]        x_q;
   logic [7:0]        y_q;
   logic              v1_q, v2_q;
   logic [16:0]       a1_q, a2_q;
   logic [32:0]       mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]   count_q;
   logic [CntW:0]     occupancy;
   logic [16:0]       fb_addr_calc;
   logic              issue, last_pix, drained, push, pop;
   logic              unused_hi;

   assign unused_hi = ^tile_bram_read_data[31:16];

   // Reads in flight count against the FIFO so an arriving word always has room.
   assign occupancy = {1'b0, count_q} + {{CntW{1'b0}}, v1_q} + {{CntW{1'b0}}, v2_q};
   assign last_pix  = (row_q == RowW'(TILE_H - 1)) && (col_q == ColW'(TILE_W - 1));
   assign drained   = !v1_q && !v2_q && (count_q == '0);
   assign fb_addr_calc = (17'(y_q) + 17'(row_q)) * 17'(SCREEN_W) + 17'(x_q) + 17'(col_q);

   assign push = v2_q;
   assign pop  = fb_write_valid && fb_write_ready;

   assign tile_bram_read_addr = addr_q;
   assign fb_write_valid      = (count_q != '0);
   assign {fb_write_addr, fb_write_data} = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (rst) state_q <= StIdle;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StIssue;
         StIssue: if (issue && last_pix) state_d = StDrain;
         StDrain: if (drained) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      busy  = (state_q != StIdle);
      issue = (state_q == StIssue) && (occupancy < (CntW + 1)'(FIFO_DEPTH));
      done  = (state_q == StDrain) && drained;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_q    <= '0;
         row_q    <= '0;
         addr_q   <= '0;
         x_q      <= '0;
         y_q      <= '0;
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         a1_q     <= '0;
         a2_q     <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (state_q == StIdle && start) begin
            x_q    <= x_offset;
            y_q    <= y_offset;
            col_q  <= '0;
            row_q  <= '0;
            addr_q <= '0;
         end else if (issue && !last_pix) begin
            addr_q <= addr_q + 10'd1;
            if (col_q == ColW'(TILE_W - 1)) begin
               col_q <= '0;
               row_q <= row_q + RowW'(1);
            end else begin
               col_q <= col_q + ColW'(1);
            end
         end
         // Matches the two-cycle BRAM latency; stage 2 lines up with the returned word.
         v1_q <= issue;
         a1_q <= fb_addr_calc;
         v2_q <= v1_q;
         a2_q <= a1_q;
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         count_q <= count_q + CntW'(push) - CntW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {a2_q, tile_bram_read_data[15:0]};
   end

endmodule

// File: tb/tb_tile_flusher.sv
// Scoreboard bench for tile_flusher: expected writes queued at start, popped per transfer.
module tb_tile_flusher;

   logic        clk = 1'b0;
   logic        rst, start, fb_write_ready;
   logic [8:0]  x_offset;
   logic [7:0]  y_offset;
   logic [9:0]  tile_bram_read_addr;
   logic [31:0] tile_bram_read_data;
   logic [16:0] fb_write_addr;
   logic [15:0] fb_write_data;
   logic        fb_write_valid, busy, done;

   int tests_run = 0;
   int failed    = 0;
   int cyc       = 0;

   logic [32:0] exp_q[$];
   int xfer_cnt = 0, done_cnt = 0, first_xfer_cyc = -1, last_xfer_cyc = 0, done_cyc = 0;
   logic [16:0] first_xfer_addr, last_xfer_addr;
   logic        pv = 1'b0, pr = 1'b0, prst = 1'b1;
   logic [16:0] pa;
   logic [15:0] pd;
   logic [9:0]  a_d1;

   tile_flusher dut (
      .clk                 (clk),
      .rst                 (rst),
      .start               (start),
      .x_offset            (x_offset),
      .y_offset            (y_offset),
      .tile_bram_read_addr (tile_bram_read_addr),
      .tile_bram_read_data (tile_bram_read_data),
      .fb_write_addr       (fb_write_addr),
      .fb_write_data       (fb_write_data),
      .fb_write_valid      (fb_write_valid),
      .fb_write_ready      (fb_write_ready),
      .busy                (busy),
      .done                (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // BRAM model: word for address a is a itself, with junk in the upper half.
   always @(posedge clk) begin
      a_d1                <= tile_bram_read_addr;
      tile_bram_read_data <= {16'hDEAD, 6'd0, a_d1};
   end

   always @(negedge clk) begin
      logic [32:0] e;
      if (pv && !pr && !prst && !rst) begin
         tests_run++;
         if (fb_write_valid !== 1'b1 || fb_write_addr !== pa || fb_write_data !== pd) begin
            failed++;
            $display("FAIL hold_stable cyc=%0d valid=%b addr=%0d data=%h want addr=%0d data=%h",
                     cyc, fb_write_valid, fb_write_addr, fb_write_data, pa, pd);
         end
      end
      if (fb_write_valid === 1'b1 && fb_write_ready === 1'b1 && !rst) begin
         tests_run++;
         if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL unexpected_write addr=%0d data=%h want none", fb_write_addr,
                     fb_write_data);
         end else begin
            e = exp_q.pop_front();
            if ({fb_write_addr, fb_write_data} !== e) begin
               failed++;
               $display("FAIL write addr=%0d data=%h want addr=%0d data=%h", fb_write_addr,
                        fb_write_data, e[32:16], e[15:0]);
            end
         end
         if (first_xfer_cyc < 0) begin
            first_xfer_cyc  = cyc;
            first_xfer_addr = fb_write_addr;
         end
         last_xfer_cyc  = cyc;
         last_xfer_addr = fb_write_addr;
         xfer_cnt++;
      end
      if (done === 1'b1 && !rst) begin
         done_cnt++;
         done_cyc = cyc;
      end
      pv   = fb_write_valid;
      pr   = fb_write_ready;
      prst = rst;
      pa   = fb_write_addr;
      pd   = fb_write_data;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog expired at cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_tile(input int x, input int y);
      for (int r = 0; r < 45; r++) begin
         for (int c = 0; c < 20; c++) begin
            int a;
            a = (y + r) * 320 + x + c;
            exp_q.push_back({17'(a), 16'(r * 20 + c)});
         end
      end
   endtask

   // Leaves the bench #1 after the edge that samples start.
   task automatic drive_start(input int x, input int y);
      step();
      start    = 1'b1;
      x_offset = 9'(x);
      y_offset = 8'(y);
      push_tile(x, y);
      first_xfer_cyc = -1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(input int d0, input int limit);
      for (int i = 0; i < limit && done_cnt == d0; i++) step();
   endtask

   task automatic test_reset();
      step();
      rst = 1'b1;
      start = 1'b1;
      fb_write_ready = 1'b1;
      step();
      step();
      tests_run += 4;
      if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy got %b want 0", busy); end
      if (fb_write_valid !== 1'b0) begin
         failed++; $display("FAIL reset_valid got %b want 0", fb_write_valid);
      end
      if (done !== 1'b0) begin failed++; $display("FAIL reset_done got %b want 0", done); end
      if (tile_bram_read_addr !== 10'd0) begin
         failed++; $display("FAIL reset_addr got %0d want 0", tile_bram_read_addr);
      end
      rst = 1'b0;
      start = 1'b0;
      step();
      tests_run++;
      if (busy !== 1'b0) begin failed++; $display("FAIL reset_start_prio got %b want 0", busy); end
   endtask

   task automatic test_basic();
      int d0, x0;
      logic [9:0] hold_a;
      fb_write_ready = 1'b1;
      d0 = done_cnt;
      x0 = xfer_cnt;
      drive_start(0, 0);
      tests_run++;
      if (busy !== 1'b1) begin failed++; $display("FAIL basic_busy got %b want 1", busy); end
      for (int k = 0; k < 4; k++) begin
         if (k > 0) step();
         tests_run++;
         if (fb_write_valid !== (k == 3)) begin
            failed++;
            $display("FAIL basic_latency k=%0d valid=%b want %b", k, fb_write_valid, k == 3);
         end
      end
      wait_done(d0, 3000);
      tests_run += 5;
      if (done_cnt != d0 + 1) begin
         failed++; $display("FAIL basic_done got %0d want %0d", done_cnt - d0, 1);
      end
      if (xfer_cnt - x0 != 900) begin
         failed++; $display("FAIL basic_count got %0d want 900", xfer_cnt - x0);
      end
      if (last_xfer_cyc - first_xfer_cyc != 899) begin
         failed++;
         $display("FAIL basic_contig span=%0d want 899", last_xfer_cyc - first_xfer_cyc);
      end
      if (done_cyc != last_xfer_cyc + 1) begin
         failed++; $display("FAIL basic_done_cyc got %0d want %0d", done_cyc, last_xfer_cyc + 1);
      end
      if (exp_q.size() != 0) begin
         failed++; $display("FAIL basic_left got %0d want 0", exp_q.size());
      end
      tests_run += 2;
      if (busy !== 1'b0) begin failed++; $display("FAIL basic_idle_busy got %b want 0", busy); end
      if (done !== 1'b0) begin failed++; $display("FAIL basic_done_pulse got %b want 0", done); end
      hold_a = tile_bram_read_addr;
      repeat (3) step();
      tests_run++;
      if (tile_bram_read_addr !== hold_a) begin
         failed++; $display("FAIL basic_addr_hold got %0d want %0d", tile_bram_read_addr, hold_a);
      end
   endtask

   task automatic test_corner();
      int d0;
      fb_write_ready = 1'b1;
      d0 = done_cnt;
      drive_start(300, 135);
      wait_done(d0, 3000);
      tests_run += 4;
      if (done_cnt != d0 + 1) begin
         failed++; $display("FAIL corner_done got %0d want 1", done_cnt - d0);
      end
      if (first_xfer_addr !== 17'd43500) begin
         failed++; $display("FAIL corner_first got %0d want 43500", first_xfer_addr);
      end
      if (last_xfer_addr !== 17'd57599) begin
         failed++; $display("FAIL corner_last got %0d want 57599", last_xfer_addr);
      end
      if (exp_q.size() != 0) begin
         failed++; $display("FAIL corner_left got %0d want 0", exp_q.size());
      end
   endtask

   task automatic test_random_ready();
      int d0, x0;
      d0 = done_cnt;
      x0 = xfer_cnt;
      fb_write_ready = 1'b0;
      drive_start(0, 0);
      for (int i = 0; i < 20000 && done_cnt == d0; i++) begin
         fb_write_ready = ($urandom_range(0, 9) < 3);
         step();
      end
      fb_write_ready = 1'b1;
      tests_run += 3;
      if (done_cnt != d0 + 1) begin
         failed++; $display("FAIL random_done got %0d want 1", done_cnt - d0);
      end
      if (xfer_cnt - x0 != 900) begin
         failed++; $display("FAIL random_count got %0d want 900", xfer_cnt - x0);
      end
      if (exp_q.size() != 0) begin
         failed++; $display("FAIL random_left got %0d want 0", exp_q.size());
      end
   endtask

   task automatic test_ready_stall();
      int d0, x0;
      logic [9:0] a10;
      d0 = done_cnt;
      x0 = xfer_cnt;
      fb_write_ready = 1'b0;
      drive_start(0, 0);
      for (int i = 0; i < 50; i++) begin
         step();
         if (i == 10) a10 = tile_bram_read_addr;
      end
      tests_run += 3;
      if (tile_bram_read_addr !== a10) begin
         failed++; $display("FAIL stall_addr got %0d want %0d", tile_bram_read_addr, a10);
      end
      if (xfer_cnt != x0) begin
         failed++; $display("FAIL stall_xfer got %0d want 0", xfer_cnt - x0);
      end
      if (fb_write_valid !== 1'b1) begin
         failed++; $display("FAIL stall_valid got %b want 1", fb_write_valid);
      end
      fb_write_ready = 1'b1;
      wait_done(d0, 3000);
      tests_run += 3;
      if (done_cnt != d0 + 1) begin
         failed++; $display("FAIL stall_done got %0d want 1", done_cnt - d0);
      end
      if (xfer_cnt - x0 != 900) begin
         failed++; $display("FAIL stall_count got %0d want 900", xfer_cnt - x0);
      end
      if (exp_q.size() != 0) begin
         failed++; $display("FAIL stall_left got %0d want 0", exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int d0, x0;
      fb_write_ready = 1'b1;
      d0 = done_cnt;
      x0 = xfer_cnt;
      drive_start(0, 0);
      for (int i = 0; i < 3000 && xfer_cnt - x0 < 400; i++) step();
      rst = 1'b1;
      fb_write_ready = 1'b0;
      step();
      rst = 1'b0;
      exp_q.delete();
      tests_run += 3;
      if (xfer_cnt - x0 != 400) begin
         failed++; $display("FAIL rstmid_count got %0d want 400", xfer_cnt - x0);
      end
      if (fb_write_valid !== 1'b0) begin
         failed++; $display("FAIL rstmid_valid got %b want 0", fb_write_valid);
      end
      if (busy !== 1'b0) begin failed++; $display("FAIL rstmid_busy got %b want 0", busy); end
      fb_write_ready = 1'b1;
      x0 = xfer_cnt;
      repeat (20) step();
      tests_run += 2;
      if (done_cnt != d0) begin failed++; $display("FAIL rstmid_no_done got %0d want 0",
                                                   done_cnt - d0); end
      if (xfer_cnt != x0) begin failed++; $display("FAIL rstmid_stale got %0d want 0",
                                                   xfer_cnt - x0); end
      drive_start(0, 0);
      wait_done(d0, 3000);
      tests_run += 3;
      if (done_cnt != d0 + 1) begin
         failed++; $display("FAIL rstmid_redo_done got %0d want 1", done_cnt - d0);
      end
      if (xfer_cnt - x0 != 900) begin
         failed++; $display("FAIL rstmid_redo_count got %0d want 900", xfer_cnt - x0);
      end
      if (exp_q.size() != 0) begin
         failed++; $display("FAIL rstmid_left got %0d want 0", exp_q.size());
      end
   endtask

   task automatic test_start_spam();
      int d0, x0;
      bit seen;
      fb_write_ready = 1'b1;
      d0 = done_cnt;
      x0 = xfer_cnt;
      seen = 1'b0;
      drive_start(40, 90);
      for (int i = 0; i < 3000 && !seen; i++) begin
         step();
         if (done === 1'b1) begin
            // Start coincident with the done pulse must not be taken.
            start = 1'b1;
            step();
            start = 1'b0;
            seen = 1'b1;
            tests_run++;
            if (busy !== 1'b0) begin
               failed++; $display("FAIL spam_done_start busy=%b want 0", busy);
            end
         end else begin
            start = (i % 5 == 0);
         end
      end
      start = 1'b0;
      repeat (10) step();
      tests_run += 4;
      if (!seen) begin failed++; $display("FAIL spam_timeout seen=0 want 1"); end
      if (done_cnt != d0 + 1) begin
         failed++; $display("FAIL spam_done got %0d want 1", done_cnt - d0);
      end
      if (xfer_cnt - x0 != 900) begin
         failed++; $display("FAIL spam_count got %0d want 900", xfer_cnt - x0);
      end
      if (exp_q.size() != 0) begin
         failed++; $display("FAIL spam_left got %0d want 0", exp_q.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      x_offset = '0;
      y_offset = '0;
      fb_write_ready = 1'b0;
      test_reset();
      test_basic();
      test_corner();
      test_random_ready();
      test_ready_stall();
      test_reset_mid();
      test_start_spam();
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
